commutation_sequencer: RTL and testbench

//  Six-step (180-deg) open-loop commutation controller for the 3-leg h_bridge.

---
 rtl/commutation_sequencer_pkg.sv | 45 ++++
 rtl/commutation_sequencer_keepalive_timer.sv | 39 +++
 rtl/commutation_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_commutation_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/commutation_sequencer_pkg.sv
// Shared definitions for the six-step commutation sequencer.
//   - state_e      : controller states
//   - DEF_*        : default timing parameters (40 MHz clock)
//   - leg_pattern  : step index -> {sw1, sw2, sw3} leg command
//   - advance_step : one commutation advance in either direction, with wrap
package commutation_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_RUN   = 3'd2,
    ST_BRAKE = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam int DEF_PERIOD_W   = 24;
  localparam int DEF_MIN_PERIOD = 400;     // 10 us
  localparam int DEF_ALIGN_CYC  = 400000;  // 10 ms
  localparam int DEF_BRAKE_CYC  = 400000;  // 10 ms
  localparam int DEF_WD_TIMEOUT = 40000;   // 1 ms
  localparam int NUM_STEPS      = 6;

  // Six-entry step table; out-of-range indices fall back to all-low.
  function automatic logic [2:0] leg_pattern(input logic [2:0] step);
    logic [2:0] legs;
    case (step)
      3'd0:    legs = 3'b100;
      3'd1:    legs = 3'b110;
      3'd2:    legs = 3'b010;
      3'd3:    legs = 3'b011;
      3'd4:    legs = 3'b001;
      3'd5:    legs = 3'b101;
      default: legs = 3'b000;
    endcase
    return legs;
  endfunction

  function automatic logic [2:0] advance_step(input logic [2:0] step, input logic rev);
    logic [2:0] nxt;
    if (rev) nxt = (step == 3'd0) ? 3'(NUM_STEPS - 1) : step - 3'd1;
    else     nxt = (step == 3'(NUM_STEPS - 1)) ? 3'd0 : step + 3'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/commutation_sequencer_keepalive_timer.sv
// Host keepalive timer.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the timeout window (kick or accepted command)
//   arm        : count only while high; counter is held at zero otherwise
//   expired    : high in the cycle the window runs out with no clear
// expired is asserted WD_TIMEOUT cycles after the last clear, so the
// consumer's state flop changes exactly WD_TIMEOUT edges after the kick edge.
module keepalive_timer
  import commutation_sequencer_pkg::*;
#(
  parameter int WD_TIMEOUT = DEF_WD_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic arm,
  output logic expired
);

  localparam int CNT_W = (WD_TIMEOUT > 1) ? $clog2(WD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(WD_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!arm || clear)     cnt_d = '0;
    else if (cnt_q != TERM) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A clear in the terminal cycle wins over expiry.
  assign expired = arm && !clear && (cnt_q == TERM);

endmodule

// File: rtl/commutation_sequencer.sv
// Six-step open-loop commutation controller for a 3-leg H-bridge.
//   clk, reset            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : host command handshake
//   cmd_run/dir/period    : run request, direction (1 = reverse), cycles per step
//   wd_kick               : host keepalive pulse
//   fault_clr             : leaves FAULT back to IDLE
//   sw1..sw3_input        : leg commands (1 = high side)
//   bridge_en, bridge_wd  : bridge enable and healthy-watchdog level
//   step_strobe           : one-cycle pulse on each commutation advance
//   fault                 : high while in FAULT
module commutation_sequencer
  import commutation_sequencer_pkg::*;
#(
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int ALIGN_CYC  = DEF_ALIGN_CYC,
  parameter int BRAKE_CYC  = DEF_BRAKE_CYC,
  parameter int WD_TIMEOUT = DEF_WD_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_run,
  input  logic                cmd_dir,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                wd_kick,
  input  logic                fault_clr,
  output logic                sw1_input,
  output logic                sw2_input,
  output logic                sw3_input,
  output logic                bridge_en,
  output logic                bridge_wd,
  output logic                step_strobe,
  output logic                fault
);

  localparam int HOLD_MAX = (ALIGN_CYC > BRAKE_CYC) ? ALIGN_CYC : BRAKE_CYC;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0]   ALIGN_T = HOLD_W'(ALIGN_CYC - 1);
  localparam logic [HOLD_W-1:0]   BRAKE_T = HOLD_W'(BRAKE_CYC - 1);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);

  state_e              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [PERIOD_W-1:0] step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [PERIOD_W-1:0] shadow_period_q, shadow_period_d;
  logic                shadow_dir_q, shadow_dir_d;
  logic [PERIOD_W-1:0] active_period_q, active_period_d;
  logic                run_pend_q, run_pend_d;

  logic                accept;
  logic [PERIOD_W-1:0] cmd_period_clamped;
  logic                hold_done;
  logic                run_terminal;
  logic                wd_arm;
  logic                wd_expired;
  logic [2:0]          legs;

  assign accept             = cmd_valid && cmd_ready;
  assign cmd_period_clamped = (cmd_period < MIN_P) ? MIN_P : cmd_period;
  assign hold_done          = (state_q == ST_ALIGN) ? (hold_q == ALIGN_T) : (hold_q == BRAKE_T);
  // Active period is never below MIN_PERIOD while in RUN, so the -1 cannot wrap.
  assign run_terminal       = (step_cnt_q == active_period_q - PERIOD_W'(1));
  assign wd_arm             = (state_q == ST_ALIGN) || (state_q == ST_RUN) || (state_q == ST_BRAKE);

  keepalive_timer #(
    .WD_TIMEOUT(WD_TIMEOUT)
  ) u_keepalive (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_kick || accept),
    .arm    (wd_arm),
    .expired(wd_expired)
  );

  // State register (also holds the datapath flops).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      step_q          <= '0;
      step_cnt_q      <= '0;
      hold_q          <= '0;
      shadow_period_q <= '0;
      shadow_dir_q    <= 1'b0;
      active_period_q <= '0;
      run_pend_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      step_q          <= step_d;
      step_cnt_q      <= step_cnt_d;
      hold_q          <= hold_d;
      shadow_period_q <= shadow_period_d;
      shadow_dir_q    <= shadow_dir_d;
      active_period_q <= active_period_d;
      run_pend_q      <= run_pend_d;
    end
  end

  // Next-state logic. Keepalive expiry overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept ? cmd_run : run_pend_q) state_d = ST_ALIGN;
      ST_ALIGN: if (accept && !cmd_run)            state_d = ST_BRAKE;
                else if (hold_done)                state_d = ST_RUN;
      ST_RUN:   if (accept && !cmd_run)            state_d = ST_BRAKE;
      ST_BRAKE: if (hold_done)                     state_d = ST_IDLE;
      ST_FAULT: if (fault_clr)                     state_d = ST_IDLE;
      default:                                     state_d = ST_IDLE;
    endcase
    if (wd_expired) state_d = ST_FAULT;
  end

  // Datapath: shadows, hold timer, step timer and step index.
  always_comb begin
    shadow_period_d = shadow_period_q;
    shadow_dir_d    = shadow_dir_q;
    active_period_d = active_period_q;
    step_d          = step_q;
    step_cnt_d      = step_cnt_q;
    hold_d          = '0;

    if (accept) begin
      shadow_period_d = cmd_period_clamped;
      shadow_dir_d    = cmd_dir;
    end

    // A run request seen during BRAKE is remembered until IDLE acts on it;
    // outside BRAKE the flag only lives for the single IDLE cycle after it.
    if (state_q == ST_BRAKE) run_pend_d = accept ? cmd_run : run_pend_q;
    else                     run_pend_d = 1'b0;

    if ((state_d == state_q) && ((state_q == ST_ALIGN) || (state_q == ST_BRAKE)))
      hold_d = hold_q + HOLD_W'(1);

    case (state_q)
      ST_IDLE: if (state_d == ST_ALIGN) begin
        step_d          = '0;
        step_cnt_d      = '0;
        active_period_d = accept ? cmd_period_clamped : shadow_period_q;
      end
      ST_ALIGN: if (state_d == ST_RUN) begin
        step_cnt_d      = '0;
        active_period_d = shadow_period_q;
      end
      ST_RUN: if (run_terminal) begin
        // Direction is only consumed at a boundary, so the shadowed value
        // is the one applied to this advance and all following ones.
        step_cnt_d      = '0;
        step_d          = advance_step(step_q, shadow_dir_q);
        active_period_d = shadow_period_q;
      end else begin
        step_cnt_d = step_cnt_q + PERIOD_W'(1);
      end
      default: ;
    endcase

    if (state_d == ST_FAULT) step_d = '0;
  end

  // Output decode from registered state/step.
  always_comb begin
    legs        = 3'b000;
    bridge_en   = 1'b0;
    bridge_wd   = 1'b1;
    fault       = 1'b0;
    cmd_ready   = 1'b1;
    step_strobe = 1'b0;
    case (state_q)
      ST_ALIGN: begin
        legs      = leg_pattern(step_q);
        bridge_en = 1'b1;
      end
      ST_RUN: begin
        legs        = leg_pattern(step_q);
        bridge_en   = 1'b1;
        step_strobe = run_terminal;
      end
      ST_BRAKE: bridge_en = 1'b1;
      ST_FAULT: begin
        bridge_wd = 1'b0;
        fault     = 1'b1;
        cmd_ready = 1'b0;
      end
      default: ;
    endcase
    // The bridge must not see a healthy watchdog while we are held in reset.
    if (reset) bridge_wd = 1'b0;
  end

  assign sw1_input = legs[2];
  assign sw2_input = legs[1];
  assign sw3_input = legs[0];

endmodule

// File: tb/tb_commutation_sequencer.sv
module tb_commutation_sequencer;

  localparam int PW   = 16;
  localparam int MINP = 8;
  localparam int ALGN = 40;
  localparam int BRK  = 30;
  localparam int WDT  = 200;

  logic          clk;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_run, cmd_dir;
  logic [PW-1:0] cmd_period;
  logic          wd_kick, fault_clr;
  logic          sw1_input, sw2_input, sw3_input;
  logic          bridge_en, bridge_wd, step_strobe, fault;
  logic [2:0]    legs;

  int n_checks;
  int n_fail;
  int cyc;
  int cur_step;
  bit auto_kick;
  logic [2:0] leg_tab [6];

  assign legs = {sw1_input, sw2_input, sw3_input};

  commutation_sequencer #(
    .PERIOD_W  (PW),
    .MIN_PERIOD(MINP),
    .ALIGN_CYC (ALGN),
    .BRAKE_CYC (BRK),
    .WD_TIMEOUT(WDT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_run    (cmd_run),
    .cmd_dir    (cmd_dir),
    .cmd_period (cmd_period),
    .wd_kick    (wd_kick),
    .fault_clr  (fault_clr),
    .sw1_input  (sw1_input),
    .sw2_input  (sw2_input),
    .sw3_input  (sw3_input),
    .bridge_en  (bridge_en),
    .bridge_wd  (bridge_wd),
    .step_strobe(step_strobe),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    wd_kick = auto_kick && (cyc % 50 == 0);
  endtask

  task automatic send(input bit run, input bit dir, input int period);
    cmd_valid  = 1'b1;
    cmd_run    = run;
    cmd_dir    = dir;
    cmd_period = PW'(period);
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] l, input logic en,
                            input logic wd, input logic flt, input logic rdy);
    check({tag, " legs"},  legs,      l);
    check({tag, " en"},    bridge_en, en);
    check({tag, " wd"},    bridge_wd, wd);
    check({tag, " fault"}, fault,     flt);
    check({tag, " ready"}, cmd_ready, rdy);
  endtask

  // Reference: a step of `period` cycles, `elapsed` of which are already
  // spent, ends with a one-cycle strobe and then moves one table slot.
  task automatic run_step(input string tag, input int elapsed, input int period, input bit rev);
    int n;
    n = 0;
    while (step_strobe !== 1'b1 && n < period + 8) begin
      tick();
      n++;
    end
    check({tag, " spacing"}, elapsed + n, period - 1);
    check({tag, " legs"}, legs, leg_tab[cur_step]);
    tick();
    cur_step = rev ? (cur_step + 5) % 6 : (cur_step + 1) % 6;
    check({tag, " strobe width"}, step_strobe, 1'b0);
    check({tag, " next legs"}, legs, leg_tab[cur_step]);
  endtask

  initial begin
    int p1, p2, p4, p5, h, n, bad, b1;
    n_checks = 0; n_fail = 0; cyc = 0; cur_step = 0; auto_kick = 1'b1;
    leg_tab[0] = 3'b100; leg_tab[1] = 3'b110; leg_tab[2] = 3'b010;
    leg_tab[3] = 3'b011; leg_tab[4] = 3'b001; leg_tab[5] = 3'b101;
    reset = 1'b1; cmd_valid = 1'b0; cmd_run = 1'b0; cmd_dir = 1'b0;
    cmd_period = '0; wd_kick = 1'b0; fault_clr = 1'b0;

    // Reset values
    tick(); tick();
    expect_out("reset", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset strobe", step_strobe, 1'b0);
    reset = 1'b0;
    tick();
    expect_out("idle", 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b1, 20);
    tick();
    check("idle run0 no start", bridge_en, 1'b0);

    // Start forward, align, then a full electrical revolution
    p1 = $urandom_range(MINP + 12, MINP);
    send(1'b1, 1'b0, p1);
    expect_out("align entry", 3'b100, 1'b1, 1'b1, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < ALGN; i++) begin
      if (legs !== 3'b100 || step_strobe !== 1'b0 || bridge_en !== 1'b1) bad++;
      tick();
    end
    check("align hold", bad, 0);
    cur_step = 0;
    for (int i = 0; i < 7; i++) run_step("fwd", 0, p1, 1'b0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("fault_clr ignored in run", {fault, bridge_en}, 2'b01);
    run_step("fwd after clr", 1, p1, 1'b0);

    // Mid-step direction/period change takes effect at the boundary
    h = p1 / 2;
    for (int i = 0; i < h; i++) tick();
    p2 = $urandom_range(40, 2 * MINP);
    send(1'b1, 1'b1, p2);
    run_step("dir change old step", h + 1, p1, 1'b1);
    for (int i = 0; i < 3; i++) run_step("rev", 0, p2, 1'b1);

    // Short period request is clamped
    for (int i = 0; i < 3; i++) tick();
    send(1'b1, 1'b0, $urandom_range(MINP - 1, 0));
    run_step("clamp old step", 4, p2, 1'b0);
    for (int i = 0; i < 2; i++) run_step("clamped", 0, MINP, 1'b0);

    // Keepalive lapse in RUN
    auto_kick = 1'b0;
    wd_kick = 1'b1;
    tick();
    n = 0;
    while (fault !== 1'b1 && n < WDT + 20) begin
      tick();
      n++;
    end
    check("wd timeout cycles", n, WDT);
    expect_out("fault", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    expect_out("fault hold", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    expect_out("fault cleared", 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Kick in the terminal cycle prevents the fault
    send(1'b1, 1'b0, MINP);
    for (int i = 0; i < WDT - 1; i++) tick();
    wd_kick = 1'b1;
    tick();
    check("terminal kick wins", fault, 1'b0);
    for (int i = 0; i < WDT - 1; i++) tick();
    check("wd window restarted", fault, 1'b0);
    tick();
    check("wd second expiry", fault, 1'b1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    auto_kick = 1'b1;

    // Brake, with a run request queued during BRAKE
    p4 = $urandom_range(MINP + 10, MINP);
    send(1'b1, 1'b0, p4);
    for (int i = 0; i < ALGN; i++) tick();
    cur_step = 0;
    for (int i = 0; i < 2; i++) run_step("pre-brake", 0, p4, 1'b0);
    h = $urandom_range(p4 - 3, 0);
    for (int i = 0; i < h; i++) tick();
    send(1'b0, 1'b0, p4);
    expect_out("brake entry", 3'b000, 1'b1, 1'b1, 1'b0, 1'b1);
    b1 = $urandom_range(BRK - 5, 1);
    bad = 0;
    for (int i = 0; i < b1; i++) begin
      tick();
      if (bridge_en !== 1'b1 || legs !== 3'b000) bad++;
    end
    p5 = $urandom_range(MINP + 10, MINP);
    send(1'b1, 1'b1, p5);
    for (int i = 0; i < BRK - 2 - b1; i++) begin
      tick();
      if (bridge_en !== 1'b1 || legs !== 3'b000) bad++;
    end
    check("brake hold", bad, 0);
    check("brake last cycle en", bridge_en, 1'b1);
    tick();
    expect_out("brake to idle", 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("pending run align", 3'b100, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < ALGN; i++) tick();
    cur_step = 0;
    for (int i = 0; i < 2; i++) run_step("pending rev", 0, p5, 1'b1);

    // Reset in the middle of RUN
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    expect_out("reset mid-run", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset mid-run strobe", step_strobe, 1'b0);
    reset = 1'b0;
    tick();
    expect_out("post reset idle", 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
